// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage sequencer:
// RV32I opcodes, the canonical NOP and the sequencer state type.
package id_hazard_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_OPI    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INST_C = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        REDIR  = 2'd2
    } id_state_e;

endpackage

// File: rtl/id_reg_use_decode.sv
// Source-register extraction for the instruction held in ID:
// which of rs1/rs2 the opcode actually reads.
module id_reg_use_decode
    import id_hazard_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        use1,
    output logic        use2
);

    logic unused_bits;

    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign unused_bits = ^{inst[31:25], inst[14:7]};

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        unique case (inst[6:0])
            OP_R, OP_STORE, OP_BRANCH: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_OPI, OP_LOAD, OP_JALR: begin
                use1 = 1'b1;
            end
            default: begin
                use1 = 1'b0;
                use2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage sequencer: owns IF/ID, arbitrates D$/I$ stalls,
// EX redirects and load-use bubbles; counts stalls and flushes.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CNT_W    = 32,
    parameter logic [31:0] NOP_INST = NOP_INST_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_inst,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             im_stall,
    input  logic             dm_stall,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    output logic [31:0]      id_inst,
    output logic [XLEN-1:0]  id_pc,
    output logic             id_valid,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    id_state_e  state_q, state_d;
    logic       redir_pend, pend_d;
    logic       ld_nop;
    logic       flush_inc;
    logic       redir_in;
    logic       load_use;
    logic [4:0] rs1, rs2;
    logic       use1, use2;

    id_reg_use_decode u_dec (
        .inst (id_inst),
        .rs1  (rs1),
        .rs2  (rs2),
        .use1 (use1),
        .use2 (use2)
    );

    assign load_use = id_valid && ex_memread && (ex_rd != 5'd0)
                      && ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));

    // A redirect arriving while the squash cycle is active targets a bubble.
    assign redir_in = ex_redirect && (state_q != REDIR);

    always_comb begin
        state_d     = state_q;
        pend_d      = redir_pend;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b0;
        ld_nop      = 1'b0;
        flush_inc   = 1'b0;
        if (!rst) begin
            idex_bubble = 1'b1;
            state_d     = RUN;
            pend_d      = 1'b0;
        end else if (dm_stall) begin
            pend_d  = redir_pend || redir_in;
            state_d = FREEZE;
        end else if (redir_in || redir_pend) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ld_nop      = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            pend_d      = 1'b0;
            state_d     = REDIR;
        end else if (im_stall) begin
            state_d = FREEZE;
            // Keep a hazarded ID instruction in place rather than drop it.
            if (load_use) begin
                idex_bubble = 1'b1;
            end else begin
                ifid_write = 1'b1;
                ld_nop     = 1'b1;
            end
        end else if (load_use) begin
            idex_bubble = 1'b1;
            state_d     = RUN;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            state_d    = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            redir_pend <= 1'b0;
            id_inst    <= NOP_INST;
            id_pc      <= '0;
            id_valid   <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            redir_pend <= pend_d;
            if (ifid_write) begin
                if (ld_nop) begin
                    id_inst  <= NOP_INST;
                    id_valid <= 1'b0;
                end else begin
                    id_inst  <= if_inst;
                    id_pc    <= if_pc;
                    id_valid <= 1'b1;
                end
            end
            if (!pc_write && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
